uart_tx_scheduler: RTL

// Shares the UART transmitter between NUM_REQUESTERS byte producers (e.g. console, debug, trace).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_scheduler_if.sv | 33 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and scheduler state encoding.
// Imported by the TX scheduler and its testbench.
package uart_pkg;

  localparam logic [31:0] UART_TX_ADDRESS = 32'h8000_0000;
  localparam logic [31:0] UART_RX_ADDRESS = 32'h8000_0004;
  localparam int          STATUS_TX_IDLE  = 0;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_STATUS = 2'd1,
    S_WRITE       = 2'd2,
    S_WAIT_WRITE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// UART IO bus between a bus master (scheduler) and the UART.
// master: drives address/strobes/write data; slave: drives read data/responses.
interface uart_tx_scheduler_if;

  logic [31:0] rw_address;
  logic        read_request;
  logic [31:0] read_data;
  logic        read_response;
  logic [7:0]  write_data;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address,
    output read_request,
    output write_data,
    output write_request,
    input  read_data,
    input  read_response,
    input  write_response
  );

  modport slave (
    input  rw_address,
    input  read_request,
    input  write_data,
    input  write_request,
    output read_data,
    output read_response,
    output write_response
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
// Ports: req_i requests, ptr_i start index, any_o/grant_o(one-hot)/idx_o result.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  assign any_o = |req_i;

  always_comb begin
    found   = 1'b0;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART transmitter among byte producers: arbitrate, poll status, write.
// Ports: clock/reset, req_valid/req_data/req_ready, bus (UART IO master), busy, timeout_error.
module uart_tx_scheduler #(
  parameter int          NUM_REQUESTERS   = 4,
  parameter logic [31:0] UART_TX_ADDRESS  = uart_pkg::UART_TX_ADDRESS,
  parameter int          RESPONSE_TIMEOUT = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  input  logic [8*NUM_REQUESTERS-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  uart_tx_scheduler_if.master         bus,
  output logic                        busy,
  output logic                        timeout_error
);

  import uart_pkg::*;

  localparam int N  = NUM_REQUESTERS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(RESPONSE_TIMEOUT + 1);

  localparam logic [CW-1:0] TMO_LAST =
    CW'(RESPONSE_TIMEOUT - 1);

  localparam logic [1:0] IDLE        = S_IDLE;
  localparam logic [1:0] WAIT_STATUS = S_WAIT_STATUS;
  localparam logic [1:0] WRITE       = S_WRITE;
  localparam logic [1:0] WAIT_WRITE  = S_WAIT_WRITE;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [7:0]    byte_q,  byte_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  rdy_q,   rdy_d;
  logic [31:0]   addr_q,  addr_d;
  logic          rd_q,    rd_d;
  logic          wr_q,    wr_d;
  logic [7:0]    wdat_q,  wdat_d;
  logic          busy_q,  busy_d;
  logic          tmo_q,   tmo_d;

  logic          gnt_any;
  logic [N-1:0]  gnt_oh;
  logic [IW-1:0] gnt_idx;
  logic          tx_idle;
  logic          unused_rd;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .any_o   (gnt_any),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx)
  );

  assign tx_idle   = bus.read_data[STATUS_TX_IDLE];
  assign unused_rd = ^bus.read_data;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    rdy_d   = '0;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          byte_d  = req_data[8*int'(gnt_idx) +: 8];
          rdy_d   = gnt_oh;
          rd_d    = 1'b1;
          addr_d  = UART_TX_ADDRESS;
          cnt_d   = '0;
          state_d = WAIT_STATUS;
          if (int'(gnt_idx) == N - 1)
            ptr_d = '0;
          else
            ptr_d = gnt_idx + IW'(1);
        end
      end
      WAIT_STATUS: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.read_response) begin
          cnt_d = '0;
          // Busy status: poll again, no limit on retries.
          if (tx_idle) begin
            wr_d    = 1'b1;
            wdat_d  = byte_q;
            state_d = WRITE;
          end else begin
            rd_d = 1'b1;
          end
        end else if (cnt_q >= TMO_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WRITE: begin
        // Strobe cycle; counter keeps running from the strobe.
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT_WRITE;
      end
      WAIT_WRITE: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.write_response) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q >= TMO_LAST) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_ready         = rdy_q;
  assign bus.rw_address    = addr_q;
  assign bus.read_request  = rd_q;
  assign bus.write_request = wr_q;
  assign bus.write_data    = wdat_q;
  assign busy              = busy_q;
  assign timeout_error     = tmo_q;

endmodule
